// File: rtl/transition_energy_monitor_pkg.sv
// Shared types, default widths and arithmetic helpers for the transition energy monitor.
package transition_energy_monitor_pkg;

    // Read-port handshake states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACK     = 2'd2
    } rd_state_t;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_E_W   = 24;

    // Saturating add on operands up to 32 bits wide.
    // Returns {overflow, sum}. When a + b exceeds max_val the sum clamps to
    // max_val and the overflow bit is set.
    function automatic logic [32:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return {1'b1, max_val};
        end
        return {1'b0, sum[31:0]};
    endfunction

endpackage

// File: rtl/transition_energy_monitor_rise_detector.sv
// Two-flop synchronizer followed by a rising-edge detector for one gate output.
module rise_detector (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-state for the synchronizer chain and the delayed copy used for edge detection.
    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Chain registers; cleared to 0 so a gate already high out of reset reads as one rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/transition_energy_monitor.sv
// Counts synchronized 0->1 transitions per gate, accumulates switching energy,
// and offers a req/ack snapshot read port that never stalls counting.
// Counter and energy widths must not exceed 32 bits (saturating helper width).
module transition_energy_monitor
    import transition_energy_monitor_pkg::*;
#(
    parameter int N_GATES     = 4,
    parameter int SEL_W       = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int E_W         = DEF_E_W,
    parameter int E_PER_TRANS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_GATES-1:0] gate_out,
    input  logic               enable,
    input  logic               clear,
    input  logic               rd_req,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic               rd_ack,
    output logic [CNT_W-1:0]   rd_count,
    output logic [E_W-1:0]     rd_total,
    output logic               overflow
);

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});
    localparam logic [31:0] E_MAX   = 32'({E_W{1'b1}});

    logic [N_GATES-1:0] rise;

    generate
        for (genvar gi = 0; gi < N_GATES; gi++) begin : g_det
            rise_detector u_rise_detector (
                .clk   (clk),
                .reset (reset),
                .d_in  (gate_out[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q [N_GATES];
    logic [CNT_W-1:0] cnt_d [N_GATES];
    logic [E_W-1:0]   total_q, total_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      rise_pop;
    logic [32:0]      cnt_sum;
    logic [32:0]      total_sum;

    // Counter/total update: clear dominates, then enabled rises are added with saturation.
    always_comb begin
        cnt_d      = cnt_q;
        total_d    = total_q;
        overflow_d = overflow_q;
        rise_pop   = '0;
        cnt_sum    = '0;
        total_sum  = '0;
        for (int i = 0; i < N_GATES; i++) begin
            rise_pop = rise_pop + 32'(rise[i]);
        end
        if (clear) begin
            for (int i = 0; i < N_GATES; i++) begin
                cnt_d[i] = '0;
            end
            total_d    = '0;
            overflow_d = 1'b0;
        end else if (enable) begin
            for (int i = 0; i < N_GATES; i++) begin
                if (rise[i]) begin
                    cnt_sum  = sat_add(32'(cnt_q[i]), 32'd1, CNT_MAX);
                    cnt_d[i] = cnt_sum[CNT_W-1:0];
                    if (cnt_sum[32]) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            if (rise_pop != '0) begin
                total_sum = sat_add(32'(total_q), rise_pop * 32'(E_PER_TRANS), E_MAX);
                total_d   = total_sum[E_W-1:0];
                if (total_sum[32]) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // Activity registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_GATES; i++) begin
                cnt_q[i] <= '0;
            end
            total_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            overflow_q <= overflow_d;
        end
    end

    rd_state_t        state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [E_W-1:0]   rd_total_q, rd_total_d;
    logic [CNT_W-1:0] sel_count;

    // Selected-counter mux; indices with no gate behind them read as zero.
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < N_GATES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_count = cnt_q[i];
            end
        end
    end

    // Read handshake: latch selector, snapshot pre-edge values, hold until request drops.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rd_count_d = rd_count_q;
        rd_total_d = rd_total_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = ST_CAPTURE;
                    sel_d   = rd_sel;
                end
            end
            ST_CAPTURE: begin
                rd_count_d = sel_count;
                rd_total_d = total_q;
                state_d    = ST_ACK;
            end
            ST_ACK: begin
                if (!rd_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rd_count_q <= '0;
            rd_total_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rd_count_q <= rd_count_d;
            rd_total_q <= rd_total_d;
        end
    end

    assign rd_ack   = (state_q == ST_ACK);
    assign rd_count = rd_count_q;
    assign rd_total = rd_total_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_transition_energy_monitor.sv
// Directed plus randomized checks of the transition energy monitor against a
// cycle-indexed behavioural model of sampled gate history, counts and energy.
module tb_transition_energy_monitor;

    localparam int N     = 4;
    localparam int SW    = 3;
    localparam int CW    = 4;
    localparam int EW    = 24;
    localparam int EPT   = 3;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int TMAX  = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  gate_out = '0;
    logic          enable = 1'b1;
    logic          clear = 1'b0;
    logic          rd_req = 1'b0;
    logic [SW-1:0] rd_sel = '0;
    logic          rd_ack;
    logic [CW-1:0] rd_count;
    logic [EW-1:0] rd_total;
    logic          overflow;

    transition_energy_monitor #(
        .N_GATES(N), .SEL_W(SW), .CNT_W(CW), .E_W(EW), .E_PER_TRANS(EPT)
    ) dut (
        .clk(clk), .reset(reset), .gate_out(gate_out), .enable(enable),
        .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack),
        .rd_count(rd_count), .rd_total(rd_total), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: gate_out as sampled at the last three edges, plus expected state.
    logic [N-1:0] s1 = '0, s2 = '0, s3 = '0;
    int  m_cnt [N];
    int  m_total = 0;
    bit  m_ovf = 1'b0;
    bit  rnd_gate = 1'b0;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_total = 0;
        m_ovf = 1'b0;
    endtask

    // One clock edge: a gate value sampled at edge n-2 that was 0 at edge n-3
    // is counted at edge n.
    task automatic tick();
        logic [N-1:0] r;
        int pop;
        if (rnd_gate) gate_out = N'($urandom);
        r = s2 & ~s3;
        if (clear) begin
            model_zero();
        end else if (enable) begin
            pop = 0;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    pop++;
                    if (m_cnt[i] == CMAX) m_ovf = 1'b1;
                    else m_cnt[i]++;
                end
            end
            if (m_total + pop * EPT > TMAX) begin
                m_total = TMAX;
                m_ovf = 1'b1;
            end else begin
                m_total = m_total + pop * EPT;
            end
        end
        @(posedge clk);
        s3 = s2; s2 = s1; s1 = gate_out;
        #1;
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_zero();
        s1 = '0; s2 = '0; s3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(rd_ack), 0);
        chk("rst_count", 32'(rd_count), 0);
        chk("rst_total", 32'(rd_total), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;
    endtask

    task automatic do_read(input int sel, input int hold, input bit drop);
        int exp_c, exp_t;
        rd_req = 1'b1;
        rd_sel = SW'(sel);
        tick();
        chk("ack_early", 32'(rd_ack), 0);
        exp_c = (sel < N) ? m_cnt[sel] : 0;
        exp_t = m_total;
        rd_sel = SW'($urandom);
        if (drop) rd_req = 1'b0;
        tick();
        chk("ack_on", 32'(rd_ack), 1);
        chk("rd_count", 32'(rd_count), 32'(exp_c));
        chk("rd_total", 32'(rd_total), 32'(exp_t));
        $display("read sel=%0d count=%0d total=%0d", sel, rd_count, rd_total);
        if (!drop) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("ack_hold", 32'(rd_ack), 1);
                chk("count_hold", 32'(rd_count), 32'(exp_c));
                chk("total_hold", 32'(rd_total), 32'(exp_t));
            end
        end
        rd_req = 1'b0;
        tick();
        chk("ack_off", 32'(rd_ack), 0);
    endtask

    task automatic pulse(input int gate, input int n);
        for (int k = 0; k < n; k++) begin
            gate_out[gate] = 1'b1; tick(); tick();
            gate_out[gate] = 1'b0; tick(); tick();
        end
    endtask

    initial begin
        // 1: single rise latency, probed with snapshots taken at different edges
        apply_reset();
        gate_out = 4'b0001;
        do_read(0, 0, 0);          // snapshot before the count lands
        do_read(0, 0, 0);
        apply_reset();
        tick();
        do_read(0, 0, 0);          // snapshot of edge-1 state: still 0
        apply_reset();
        tick(); tick();
        do_read(0, 0, 0);          // snapshot of edge-2 state: count 1
        do_read(1, 0, 0);
        do_read(5, 0, 0);          // out-of-range selector

        // 2: all gates rise together
        apply_reset();
        gate_out = 4'hF;
        repeat (3) tick();
        do_read(3, 1, 0);
        chk("total_all4", 32'(rd_total), 32'(4 * EPT));

        // 3: saturation, clear, clear versus simultaneous rise
        apply_reset();
        gate_out = '0;
        tick(); tick();
        pulse(1, 17);
        do_read(1, 0, 0);
        chk("sat_count", 32'(rd_count), 32'(CMAX));
        chk("sat_ovf", 32'(overflow), 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_ovf", 32'(overflow), 0);
        gate_out[1] = 1'b1;
        clear = 1'b1;
        repeat (4) tick();
        clear = 1'b0;
        do_read(1, 0, 0);
        chk("clear_wins", 32'(rd_count), 0);

        // 4: snapshot held stable while a rise lands during ACK
        gate_out = '0;
        tick(); tick(); tick();
        pulse(2, 5);
        gate_out[2] = 1'b1;
        do_read(2, 4, 0);
        chk("ack_snap5", 32'(rd_count), 5);
        do_read(2, 0, 1);
        chk("next_read6", 32'(rd_count), 6);

        // 5: enable gating
        gate_out = '0;
        enable = 1'b0;
        pulse(0, 10);
        do_read(0, 0, 0);
        enable = 1'b1;
        pulse(0, 1);
        do_read(0, 0, 0);

        // 6: reset while in ACK
        rd_req = 1'b1; rd_sel = 3'd2;
        tick(); tick();
        chk("pre_rst_ack", 32'(rd_ack), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ack", 32'(rd_ack), 0);
        chk("async_count", 32'(rd_count), 0);
        chk("async_total", 32'(rd_total), 0);
        rd_req = 1'b0;
        apply_reset();
        gate_out = '0;
        tick();
        chk("idle_after_rst", 32'(rd_ack), 0);
        do_read(2, 0, 0);

        // Randomized activity with interleaved reads
        rnd_gate = 1'b1;
        for (int it = 0; it < 60; it++) begin
            enable = ($urandom_range(3) != 0);
            clear  = ($urandom_range(15) == 0);
            repeat ($urandom_range(1, 8)) tick();
            clear = 1'b0;
            do_read(int'($urandom_range(7)), int'($urandom_range(2)), 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, required completion", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/transition_energy_monitor.md
Name: transition_energy_monitor

Overview:
- Collects 0->1 output transitions from up to N_GATES gate-model outputs and keeps a per-gate event count plus a total energy tally, where each rising transition costs E_PER_TRANS units.
- Sits beside the structural netlists as the single point where switching activity is read out, replacing the per-instance internal counters.
- Exposes a req/ack snapshot read port so the testbench or a downstream logger reads coherent values while counting continues.

Parameters:
- N_GATES, 4, number of monitored gate outputs (>=1).
- SEL_W, 2, width of rd_sel; must satisfy 2**SEL_W >= N_GATES.
- CNT_W, 16, width of each per-gate transition counter.
- E_W, 24, width of the total energy accumulator.
- E_PER_TRANS, 1, energy units added per rising transition (>=1, fits in E_W).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- gate_out  in  N_GATES  monitored gate outputs; asynchronous to clk.
- enable  in  1  when 0, detected rises are not counted; synchronizers keep running.
- clear  in  1  synchronous clear of all counters, total and overflow.
- rd_req  in  1  read request (level).
- rd_sel  in  SEL_W  gate index to read; sampled with the request.
- rd_ack  out  1  read data valid.
- rd_count  out  CNT_W  snapshot of the selected gate counter.
- rd_total  out  E_W  snapshot of the total energy.
- overflow  out  1  sticky saturation flag.

Behaviour:
- Reset (async, immediate): all sync/prev flops 0, counters 0, total 0, overflow 0, FSM IDLE, rd_ack 0, rd_count 0, rd_total 0.
- Per gate i: sync1<=gate_out[i]; sync2<=sync1; prev<=sync2; rise[i]=sync2&~prev.
  - A rise applied before edge 0 updates the counter at edge 2, visible after 3 clock edges.
  - Input pulses shorter than one clk period may be missed; this is accepted.
  - gate_out=1 out of reset counts as one rise.
- Counting when enable=1 and clear=0:
  - cnt[i] += rise[i].
  - total += popcount(rise) * E_PER_TRANS, so simultaneous rises on several gates all count in the same cycle.
- Saturation:
  - A counter or the total that would exceed all-ones holds at all-ones and sets overflow.
  - overflow stays set until clear or reset.
- clear=1 wins over a same-cycle rise: counters, total and overflow are 0 after the edge, and that cycle's rises are discarded. The read FSM is unaffected.
- Read FSM states: IDLE, CAPTURE, ACK.
  - IDLE: rd_req=1 -> CAPTURE, latching rd_sel.
  - CAPTURE: rd_count<=cnt[sel], rd_total<=total, taking values after this edge's update is excluded, i.e. pre-edge register values. -> ACK.
  - ACK: rd_ack=1, outputs held stable. rd_req=0 -> IDLE, with rd_ack 0 on the following cycle.
  - rd_ack is asserted 2 cycles after rd_req is first sampled high.
  - rd_sel changes after IDLE are ignored. rd_sel >= N_GATES returns rd_count=0.
  - rd_req dropping during CAPTURE still completes to ACK, which then exits on the next cycle.
  - Counting continues in every FSM state.
- Reset mid-read: FSM returns to IDLE and rd_ack deasserts immediately.

Decomposition:
- Shared package holds:
  - the FSM state typedef (IDLE/CAPTURE/ACK);
  - default width constants (CNT_W, E_W);
  - a saturating-add helper function.
- One sub-module, rise_detector: per-gate two-flop synchronizer plus edge detect, with async active-high reset. It is instantiated N_GATES times via generate.

Test Plan:
1. Reset, then gate_out[0] rises once and stays high -> cnt[0]=1 exactly 3 edges later; total=E_PER_TRANS; other counts 0.
2. All 4 gates rise in the same cycle with E_PER_TRANS=3 -> total=12 and every cnt=1 in a single update.
3. CNT_W=4 with 17 rises on gate 1 -> cnt[1]=15, overflow=1; then clear=1 -> all 0 and overflow=0. clear held high together with a rise -> count stays 0.
4. Read rd_sel=2 with cnt[2]=5 -> rd_ack high 2 cycles after rd_req; rd_count=5. A gate-2 rise during ACK leaves rd_count=5; the next read returns 6.
5. enable=0 while gate 0 toggles 10 times -> cnt[0] unchanged; enable=1 and one more rise -> +1.
6. Assert reset during ACK -> rd_ack=0 immediately with no clock; counters and total 0; FSM in IDLE on release.
